// File: rtl/ctrl_pkg.sv
// Shared types and ISA constants for the instruction sequencing controller.
package ctrl_pkg;

    // Field widths of the fixed 16-bit instruction format.
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 3;
    localparam int OP_W    = 2;
    localparam int REG_W   = 3;
    localparam int SH_W    = 2;
    localparam int IMM8_W  = 8;

    // Opcode and op field encodings.
    localparam logic [OPC_W-1:0] OPC_MOV    = 3'b110;
    localparam logic [OPC_W-1:0] OPC_ALU    = 3'b101;
    localparam logic [OP_W-1:0]  OP_MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0]  OP_MOV_REG = 2'b00;
    localparam logic [OP_W-1:0]  OP_ADD     = 2'b00;
    localparam logic [OP_W-1:0]  OP_CMP     = 2'b01;
    localparam logic [OP_W-1:0]  OP_AND     = 2'b10;
    localparam logic [OP_W-1:0]  OP_MVN     = 2'b11;

    // Controller states; all eight encodings of the 3-bit register are used.
    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        GET_A,
        GET_B,
        EXEC,
        WR_IMM,
        WR_RES,
        DONE
    } state_t;

    // Instruction classes, one per distinct state sequence.
    typedef enum logic [2:0] {
        CLS_MOV_IMM,   // immediate to Rn
        CLS_MOV_REG,   // shifted Rm to Rd, ALU A forced to zero
        CLS_ALU_AB,    // ADD / AND: reads Rn and Rm, writes Rd
        CLS_ALU_B,     // MVN: reads Rm only, writes Rd
        CLS_CMP,       // reads Rn and Rm, updates status only
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and classification of the latched instruction.
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int W    = 16,
    parameter int RN_W = 3
) (
    input  logic [W-1:0]    instr_q,
    output logic [RN_W-1:0] rn,
    output logic [RN_W-1:0] rd,
    output logic [RN_W-1:0] rm,
    output logic [1:0]      sh,
    output logic [1:0]      op,
    output logic [W-1:0]    sximm8,
    output instr_class_t    instr_class,
    output logic            illegal
);

    logic [OPC_W-1:0] opcode;

    assign opcode = instr_q[15:13];
    assign op     = instr_q[12:11];
    assign rn     = instr_q[10:8];
    assign rd     = instr_q[7:5];
    assign sh     = instr_q[4:3];
    assign rm     = instr_q[2:0];
    assign sximm8 = {{(W-IMM8_W){instr_q[IMM8_W-1]}}, instr_q[IMM8_W-1:0]};

    // Map opcode/op onto the sequence class; anything unlisted is illegal.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      instr_class = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) instr_class = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  instr_class = CLS_ALU_AB;
                OP_AND:  instr_class = CLS_ALU_AB;
                OP_CMP:  instr_class = CLS_CMP;
                default: instr_class = CLS_ALU_B;
            endcase
        end
    end

    assign illegal = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle controller: latches an instruction on start, then steps the
// regfile reads, ALU execute and write-back with Moore-decoded controls.
module instr_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int W    = 16,
    parameter int RN_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    instr,
    output logic            done,
    output logic            busy,
    output logic            illegal,
    output logic [RN_W-1:0] readnum,
    output logic [RN_W-1:0] writenum,
    output logic            write,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            vsel,
    output logic [W-1:0]    sximm8,
    output logic [1:0]      shift,
    output logic [1:0]      alu_op
);

    state_t          state, state_nx;
    logic [W-1:0]    instr_q;
    logic [RN_W-1:0] rn, rd, rm;
    logic [1:0]      sh, op;
    logic [W-1:0]    imm_sx;
    instr_class_t    instr_class;
    logic            dec_illegal;
    logic            is_alu;

    instr_decode #(
        .W    (W),
        .RN_W (RN_W)
    ) u_decode (
        .instr_q     (instr_q),
        .rn          (rn),
        .rd          (rd),
        .rm          (rm),
        .sh          (sh),
        .op          (op),
        .sximm8      (imm_sx),
        .instr_class (instr_class),
        .illegal     (dec_illegal)
    );

    assign is_alu = (instr_class == CLS_ALU_AB) || (instr_class == CLS_ALU_B) ||
                    (instr_class == CLS_CMP);

    // Instruction latch: captured only when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       instr_q <= '0;
        else if (state == IDLE && start)  instr_q <= instr;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state sequencing and Moore output decode.
    always_comb begin
        state_nx = IDLE;
        done     = 1'b0;
        busy     = 1'b1;
        illegal  = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = 1'b0;
        sximm8   = imm_sx;
        shift    = sh;
        alu_op   = op;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                state_nx = start ? DECODE : IDLE;
            end
            DECODE: begin
                case (instr_class)
                    CLS_MOV_IMM: state_nx = WR_IMM;
                    CLS_MOV_REG: state_nx = GET_B;
                    CLS_ALU_B:   state_nx = GET_B;
                    CLS_ALU_AB:  state_nx = GET_A;
                    CLS_CMP:     state_nx = GET_A;
                    default:     state_nx = DONE;
                endcase
            end
            GET_A: begin
                readnum  = rn;
                loada    = 1'b1;
                state_nx = GET_B;
            end
            GET_B: begin
                readnum  = rm;
                loadb    = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                loadc    = (instr_class != CLS_CMP);
                loads    = is_alu;
                asel     = (instr_class == CLS_MOV_REG);
                state_nx = (instr_class == CLS_CMP) ? DONE : WR_RES;
            end
            WR_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
                state_nx = DONE;
            end
            WR_RES: begin
                writenum = rd;
                write    = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                illegal  = dec_illegal;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench: controller paired with a behavioural regfile and datapath.
module tb_instr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] instr;
    logic        done, busy, illegal;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, vsel;
    logic [15:0] sximm8;
    logic [1:0]  shift, alu_op;

    int checks   = 0;
    int failures = 0;

    instr_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .instr    (instr),
        .done     (done),
        .busy     (busy),
        .illegal  (illegal),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .sximm8   (sximm8),
        .shift    (shift),
        .alu_op   (alu_op)
    );

    always #5 clk = ~clk;

    // Regfile and datapath environment.
    logic        model_clr;
    logic [15:0] rf [8];
    logic [15:0] a_q, b_q, c_q, b_sh, ain, alu_out;
    logic        z_q;

    always_comb begin
        case (shift)
            2'b00:   b_sh = b_q;
            2'b01:   b_sh = {b_q[14:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[15:1]};
            default: b_sh = {b_q[15], b_q[15:1]};
        endcase
        ain = asel ? 16'h0000 : a_q;
        case (alu_op)
            2'b00:   alu_out = ain + b_sh;
            2'b01:   alu_out = ain - b_sh;
            2'b10:   alu_out = ain & b_sh;
            default: alu_out = ~b_sh;
        endcase
    end

    always @(posedge clk) begin
        if (model_clr) begin
            for (int k = 0; k < 8; k++) rf[k] <= 16'h0000;
            a_q <= '0; b_q <= '0; c_q <= '0; z_q <= 1'b0;
        end else begin
            if (write) rf[writenum] <= vsel ? sximm8 : c_q;
            if (loada) a_q <= rf[readnum];
            if (loadb) b_q <= rf[readnum];
            if (loadc) c_q <= alu_out;
            if (loads) z_q <= (alu_out == 16'h0000);
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Issue one instruction and observe each cycle until done (bounded).
    task automatic run_instr(input logic [15:0] i, input bit hold,
                             output int cyc, output int wr, output int ld,
                             output int lc, output int as, output int bz,
                             output logic ill);
        bit got;
        got = 0; cyc = 0; wr = 0; ld = 0; lc = 0; as = 0; bz = 0; ill = 1'bx;
        @(negedge clk);
        instr = i;
        start = 1'b1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            cyc++;
            if (write) wr++;
            if (loads) ld++;
            if (loadc) lc++;
            if (asel)  as++;
            if (busy)  bz++;
            if (done) begin
                got = 1;
                ill = illegal;
            end
        end
        if (!got) cyc = -1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [15:0] instr;
        int          cycles;
        int          writes;
        int          loads_n;
        int          loadc_n;
        int          asel_n;
        logic        ill;
        logic [2:0]  rnum;
        logic [15:0] rval;
        logic        z;
    } vec_t;

    function automatic vec_t mk(string n, logic [15:0] i, int c, int w, int ls, int lc,
                                int as, logic il, logic [2:0] r, logic [15:0] v, logic z);
        vec_t t;
        t.name = n; t.instr = i; t.cycles = c; t.writes = w; t.loads_n = ls;
        t.loadc_n = lc; t.asel_n = as; t.ill = il; t.rnum = r; t.rval = v; t.z = z;
        return t;
    endfunction

    vec_t vecs [9];

    initial begin
        int   cyc, wr, ld, lc, as, bz, n;
        logic ill;

        // Expected register contents accumulate across the table in order.
        vecs[0] = mk("mov_imm_r1",  16'hD105, 3, 1, 0, 0, 0, 1'b0, 3'd1, 16'h0005, 1'b0);
        vecs[1] = mk("mov_neg_r2",  16'hD2FF, 3, 1, 0, 0, 0, 1'b0, 3'd2, 16'hFFFF, 1'b0);
        vecs[2] = mk("add_r3",      16'hA162, 6, 1, 1, 1, 0, 1'b0, 3'd3, 16'h0004, 1'b0);
        vecs[3] = mk("cmp_r1_r1",   16'hA901, 5, 0, 1, 0, 0, 1'b0, 3'd3, 16'h0004, 1'b1);
        vecs[4] = mk("mvn_r5",      16'hB8A1, 5, 1, 1, 1, 0, 1'b0, 3'd5, 16'hFFFA, 1'b0);
        vecs[5] = mk("and_r6",      16'hB1C2, 6, 1, 1, 1, 0, 1'b0, 3'd6, 16'h0005, 1'b0);
        vecs[6] = mk("opc111",      16'hE000, 2, 0, 0, 0, 0, 1'b1, 3'd0, 16'h0000, 1'b0);
        vecs[7] = mk("mov_op01",    16'hC800, 2, 0, 0, 0, 0, 1'b1, 3'd1, 16'h0005, 1'b0);
        vecs[8] = mk("mov_imm_sx",  16'hD780, 3, 1, 0, 0, 0, 1'b0, 3'd7, 16'hFF80, 1'b0);

        rst_n = 1'b0; start = 1'b0; instr = 16'h0000; model_clr = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {done, busy, illegal, readnum, writenum, write, loada, loadb, loadc,
               loads, asel, vsel, sximm8, shift, alu_op}, 64'd0);
        rst_n = 1'b1; model_clr = 1'b0;
        @(negedge clk);

        foreach (vecs[v]) begin
            run_instr(vecs[v].instr, 1'b0, cyc, wr, ld, lc, as, bz, ill);
            check({vecs[v].name, "_cycles"}, cyc, vecs[v].cycles);
            check({vecs[v].name, "_busy"},   bz,  vecs[v].cycles);
            check({vecs[v].name, "_writes"}, wr,  vecs[v].writes);
            check({vecs[v].name, "_loads"},  ld,  vecs[v].loads_n);
            check({vecs[v].name, "_loadc"},  lc,  vecs[v].loadc_n);
            check({vecs[v].name, "_illegal"}, ill, vecs[v].ill);
            check({vecs[v].name, "_reg"},    rf[vecs[v].rnum], vecs[v].rval);
            check({vecs[v].name, "_z"},      z_q, vecs[v].z);
            check({vecs[v].name, "_idle_after"}, busy, 1'b0);
        end

        // MOV R4,R1,LSL#1 (Rd=4, sh=01, Rm=1) with start held high through DONE.
        run_instr(16'hC089, 1'b1, cyc, wr, ld, lc, as, bz, ill);
        check("movsh_cycles", cyc, 5);
        check("movsh_asel",   as,  1);
        check("movsh_writes", wr,  1);
        check("movsh_reg",    rf[4], 16'h000A);
        check("movsh_once_busy", busy, 1'b0);
        @(negedge clk);
        check("movsh_once_busy2", busy, 1'b0);

        // ADD R0,R1,R2 interrupted by reset during its write-back cycle.
        @(negedge clk);
        instr = 16'hA102;
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!write && n < 10);
        check("rst_reach_wr_res", n, 5);
        #1 rst_n = 1'b0;
        #1 check("rst_outputs_zero",
                 {done, busy, illegal, readnum, writenum, write, loada, loadb, loadc,
                  loads, asel, vsel, sximm8, shift, alu_op}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_target_unchanged", rf[0], 16'h0000);

        // Next start after reset: ADD R1,R1,R1 (Rd equals both sources).
        run_instr(16'hA121, 1'b0, cyc, wr, ld, lc, as, bz, ill);
        check("post_rst_cycles", cyc, 6);
        check("post_rst_writes", wr, 1);
        check("post_rst_reg",    rf[1], 16'h000A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
